// File: rtl/updown_mod_counter.sv
// Synchronous loadable modulo-N up/down counter.
// Terminal count is combinational so stages can be cascaded on one clock.
module updown_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  // Range end kept one bit wider so MODULUS = 2^WIDTH still compares correctly
  localparam logic [WIDTH:0]   TOP   = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] TOP_Q = TOP[WIDTH-1:0];

  logic [WIDTH:0]   q_ext;
  logic [WIDTH:0]   lv_ext;
  logic             at_top;
  logic             at_bot;
  logic [WIDTH-1:0] q_next;
  logic             wrap_next;
  logic             ovf_set;
  logic             ovf_next;

  assign q_ext  = {1'b0, q};
  assign lv_ext = {1'b0, load_val};
  assign at_top = (q_ext == TOP);
  assign at_bot = (q_ext == '0);

  assign tc = en & ((up & at_top) | (~up & at_bot));

  always_comb begin
    q_next    = q;
    wrap_next = 1'b0;
    ovf_set   = 1'b0;
    if (load) begin
      if (lv_ext <= TOP) begin
        q_next = load_val;
      end else begin
        q_next  = TOP_Q;
        ovf_set = 1'b1;
      end
    end else if (en) begin
      if (up) begin
        if (!at_top) begin
          q_next = q + WIDTH'(1);
        end else if (!sat) begin
          q_next    = '0;
          wrap_next = 1'b1;
          ovf_set   = 1'b1;
        end else begin
          ovf_set = 1'b1;
        end
      end else begin
        if (!at_bot) begin
          q_next = q - WIDTH'(1);
        end else if (!sat) begin
          q_next    = TOP_Q;
          wrap_next = 1'b1;
          ovf_set   = 1'b1;
        end else begin
          ovf_set = 1'b1;
        end
      end
    end
  end

  // A set event on the same edge as clr_ovf leaves the flag high
  assign ovf_next = ovf_set | (ovf & ~clr_ovf);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= '0;
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      q    <= q_next;
      wrap <= wrap_next;
      ovf  <= ovf_next;
    end
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench for updown_mod_counter (WIDTH=4, MODULUS=10).
// Also chains two instances through tc to check synchronous cascading.
module tb_updown_mod_counter;

  logic       clk = 1'b0;
  logic       rst, en, up, sat, load, clr_ovf;
  logic [3:0] load_val;
  logic [3:0] q;
  logic       tc, wrap, ovf;

  logic       c_rst, c_en;
  logic [3:0] lo_q, hi_q;
  logic       lo_tc, lo_wrap, lo_ovf;
  logic       hi_tc, hi_wrap, hi_ovf;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat),
    .load(load), .load_val(load_val), .clr_ovf(clr_ovf),
    .q(q), .tc(tc), .wrap(wrap), .ovf(ovf)
  );

  updown_mod_counter #(.WIDTH(4), .MODULUS(10)) u_lo (
    .clk(clk), .rst(c_rst), .en(c_en), .up(1'b1), .sat(1'b0),
    .load(1'b0), .load_val(4'd0), .clr_ovf(1'b0),
    .q(lo_q), .tc(lo_tc), .wrap(lo_wrap), .ovf(lo_ovf)
  );

  updown_mod_counter #(.WIDTH(4), .MODULUS(10)) u_hi (
    .clk(clk), .rst(c_rst), .en(lo_tc), .up(1'b1), .sat(1'b0),
    .load(1'b0), .load_val(4'd0), .clr_ovf(1'b0),
    .q(hi_q), .tc(hi_tc), .wrap(hi_wrap), .ovf(hi_ovf)
  );

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk3(input string tag, input logic [3:0] eq,
                      input logic ew, input logic eo);
    chk({tag, ".q"}, {4'd0, q}, {4'd0, eq});
    chk({tag, ".wrap"}, {7'd0, wrap}, {7'd0, ew});
    chk({tag, ".ovf"}, {7'd0, ovf}, {7'd0, eo});
  endtask

  initial begin
    rst = 1'b1; en = 0; up = 0; sat = 0; load = 0;
    clr_ovf = 0; load_val = 4'd0;
    c_rst = 1'b1; c_en = 1'b0;
    step(); step();
    chk3("reset", 4'd0, 1'b0, 1'b0);
    rst = 1'b0; c_rst = 1'b0;

    // clamped load gives q=9 ovf=1, then count down to 7
    load = 1; load_val = 4'd12;
    step();
    chk3("clamp12", 4'd9, 1'b0, 1'b1);
    load = 0; en = 1; up = 0;
    step(); step();
    chk3("down_to7", 4'd7, 1'b0, 1'b1);

    // asynchronous reset mid-cycle
    #3 rst = 1'b1;
    #1 chk3("async_rst", 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    up = 1;
    step();
    chk3("post_rst", 4'd1, 1'b0, 1'b0);

    // up wrap
    en = 0; load = 1; load_val = 4'd8;
    step();
    chk3("load8", 4'd8, 1'b0, 1'b0);
    load = 0; en = 1; up = 1; sat = 0;
    #1 chk("tc_at8", {7'd0, tc}, 8'd0);
    step();
    chk3("up9", 4'd9, 1'b0, 1'b0);
    chk("tc_at9", {7'd0, tc}, 8'd1);
    step();
    chk3("upwrap0", 4'd0, 1'b1, 1'b1);
    chk("tc_at0", {7'd0, tc}, 8'd0);
    step();
    chk3("up1", 4'd1, 1'b0, 1'b1);

    // down wrap and direction reversal
    en = 0; load = 1; load_val = 4'd1; clr_ovf = 1;
    step();
    chk3("load1", 4'd1, 1'b0, 1'b0);
    load = 0; clr_ovf = 0; en = 1; up = 0;
    step();
    chk3("down0", 4'd0, 1'b0, 1'b0);
    chk("tc_down0", {7'd0, tc}, 8'd1);
    step();
    chk3("downwrap9", 4'd9, 1'b1, 1'b1);
    up = 1;
    step();
    chk3("revwrap0", 4'd0, 1'b1, 1'b1);
    en = 0;
    step();
    chk3("hold0", 4'd0, 1'b0, 1'b1);

    // saturate at bottom
    clr_ovf = 1;
    step();
    chk3("clr", 4'd0, 1'b0, 1'b0);
    clr_ovf = 0; sat = 1; up = 0; en = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk3("sat_bot", 4'd0, 1'b0, 1'b1);
    end
    en = 0; clr_ovf = 1;
    step();
    chk3("sat_clr", 4'd0, 1'b0, 1'b0);

    // saturate at top
    clr_ovf = 0; load = 1; load_val = 4'd9;
    step();
    chk3("load9", 4'd9, 1'b0, 1'b0);
    load = 0; en = 1; up = 1;
    step();
    chk3("sat_top", 4'd9, 1'b0, 1'b1);

    // load priority and clamp
    en = 0; sat = 0; clr_ovf = 1;
    step();
    load = 1; load_val = 4'd13; en = 1; up = 1; clr_ovf = 0;
    step();
    chk3("clamp13", 4'd9, 1'b0, 1'b1);
    load_val = 4'd4; clr_ovf = 1;
    step();
    chk3("load4_clr", 4'd4, 1'b0, 1'b0);
    load_val = 4'd10; clr_ovf = 0;
    step();
    chk3("clamp10", 4'd9, 1'b0, 1'b1);
    load_val = 4'd15; clr_ovf = 1;
    step();
    chk3("clamp15_setwins", 4'd9, 1'b0, 1'b1);

    // set beats clear on a wrap
    load_val = 4'd9;
    step();
    chk3("load9b", 4'd9, 1'b0, 1'b0);
    load = 0; en = 1; up = 1; clr_ovf = 1;
    step();
    chk3("wrap_setwins", 4'd0, 1'b1, 1'b1);
    en = 0; clr_ovf = 0;

    // two-stage cascade, 25 edges from 0
    c_en = 1'b1;
    for (int i = 0; i < 25; i++) step();
    c_en = 1'b0;
    step();
    chk("casc_lo", {4'd0, lo_q}, 8'd5);
    chk("casc_hi", {4'd0, hi_q}, 8'd2);
    chk("casc_hi_ovf", {7'd0, hi_ovf}, 8'd0);
    chk("casc_lo_ovf", {7'd0, lo_ovf}, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
